// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem writeback path.
// Entry fields are sized for the widest supported configuration. The arbiter narrows them to its parameters.
package fpu_ss_pkg;

    localparam int unsigned WB_DATA_W = 64;
    localparam int unsigned WB_ID_W   = 16;
    localparam int unsigned NUM_FPR   = 32;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [4:0]           rd;
        logic                 rd_is_fp;
        logic [WB_ID_W-1:0]   id;
        logic [4:0]           fflags;
    } wb_entry_t;

    function automatic logic [NUM_FPR-1:0] rd_onehot(input logic [4:0] rd);
        return NUM_FPR'(1) << rd;
    endfunction

endpackage

// File: rtl/fpu_ss_wb_buffer.sv
// Fall-through FIFO of writeback entries. When the FIFO is empty, the offered entry is the head.
// push_i is the offered valid. Acceptance is gated internally by full/pop, so callers avoid a ready loop.
module fpu_ss_wb_buffer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_entry_t        entry_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             head_valid_o,
    output wb_entry_t        head_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_entry_t        mem_q [DEPTH];
    logic             store, drop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign head_valid_o = !empty_o | push_i;
    assign head_o       = empty_o ? entry_i : mem_q[rd_ptr_q];
    assign entries_o    = mem_q;
    assign valid_o      = valid_q;

    // A pop with an empty FIFO consumes the fall-through entry, so nothing is stored.
    assign drop  = pop_i & !empty_o;
    assign store = push_i & (!full_o | pop_i) & !(empty_o & pop_i);

    // Clear before set: when the FIFO is full and pops, the freed slot is refilled in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (drop)  valid_d[rd_ptr_q] = 1'b0;
        if (store) valid_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (store) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (drop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(store) - CNT_W'(drop);
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fpu_ss_wb_arbiter.sv
// FPR write-port and X-result arbiter. LSU load writes always win the FPR port.
// FPnew results retire in order through a fall-through buffer.
module fpu_ss_wb_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned FLEN       = 32,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fpu_out_valid_i,
    output logic                  fpu_out_ready_o,
    input  logic [FLEN-1:0]       fpu_out_data_i,
    input  logic [4:0]            fpu_out_rd_i,
    input  logic                  fpu_out_rd_is_fp_i,
    input  logic [X_ID_WIDTH-1:0] fpu_out_id_i,
    input  logic [4:0]            fpu_out_fflags_i,
    input  logic                  mem_result_valid_i,
    input  logic                  mem_result_we_i,
    input  logic [4:0]            mem_result_rd_i,
    input  logic [FLEN-1:0]       mem_result_data_i,
    output logic                  fpr_we_o,
    output logic [4:0]            fpr_waddr_o,
    output logic [FLEN-1:0]       fpr_wdata_o,
    output logic                  fpr_wsrc_lsu_o,
    output logic                  x_result_valid_o,
    input  logic                  x_result_ready_i,
    output logic [X_ID_WIDTH-1:0] x_result_id_o,
    output logic [31:0]           x_result_data_o,
    output logic                  x_result_we_o,
    output logic [4:0]            x_result_fflags_o,
    output logic [31:0]           pending_rd_o,
    output logic                  buf_empty_o
);

    wb_entry_t            in_entry, head;
    wb_entry_t            entries [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] entry_valid;
    logic                 full, empty, head_valid, pop, fpr_block, head_ok;
    logic                 unused_bits;

    always_comb begin
        in_entry          = '0;
        in_entry.data     = WB_DATA_W'(fpu_out_data_i);
        in_entry.rd       = fpu_out_rd_i;
        in_entry.rd_is_fp = fpu_out_rd_is_fp_i;
        in_entry.id       = WB_ID_W'(fpu_out_id_i);
        in_entry.fflags   = fpu_out_fflags_i;
    end

    fpu_ss_wb_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (fpu_out_valid_i),
        .entry_i      (in_entry),
        .pop_i        (pop),
        .full_o       (full),
        .empty_o      (empty),
        .head_valid_o (head_valid),
        .head_o       (head),
        .entries_o    (entries),
        .valid_o      (entry_valid)
    );

    // An FP-destination head may only retire when the LSU is not taking the FPR port.
    assign fpr_block       = mem_result_valid_i & mem_result_we_i;
    assign head_ok         = !head.rd_is_fp | !fpr_block;
    assign pop             = head_valid & x_result_ready_i & head_ok;
    assign fpu_out_ready_o = !full | pop;
    assign buf_empty_o     = empty;

    always_comb begin
        x_result_valid_o  = head_valid & head_ok;
        x_result_id_o     = '0;
        x_result_data_o   = '0;
        x_result_we_o     = 1'b0;
        x_result_fflags_o = '0;
        if (x_result_valid_o) begin
            x_result_id_o     = X_ID_WIDTH'(head.id);
            x_result_we_o     = !head.rd_is_fp;
            x_result_fflags_o = head.fflags;
            if (!head.rd_is_fp) x_result_data_o = head.data[31:0];
        end
    end

    always_comb begin
        fpr_we_o       = 1'b0;
        fpr_waddr_o    = '0;
        fpr_wdata_o    = '0;
        fpr_wsrc_lsu_o = 1'b0;
        if (fpr_block) begin
            fpr_we_o       = 1'b1;
            fpr_waddr_o    = mem_result_rd_i;
            fpr_wdata_o    = mem_result_data_i;
            fpr_wsrc_lsu_o = 1'b1;
        end else if (pop && head.rd_is_fp) begin
            fpr_we_o    = 1'b1;
            fpr_waddr_o = head.rd;
            fpr_wdata_o = FLEN'(head.data);
        end
    end

    // Stored entries only; a fall-through result is not yet a pending write.
    always_comb begin
        pending_rd_o = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (entry_valid[i] && entries[i].rd_is_fp) pending_rd_o |= rd_onehot(entries[i].rd);
        end
    end

    // Entry fields wider than this configuration needs are folded into a sink.
    always_comb begin
        unused_bits = ^{head.data, head.id};
        for (int i = 0; i < BUF_DEPTH; i++) begin
            unused_bits ^= ^{entries[i].data, entries[i].id, entries[i].fflags};
        end
    end

endmodule
